// File: rtl/flash_stream_pkg.sv
// flash_stream_pkg: FSM encoding and default widths
// shared by the flash stream reader and its FIFO.
package flash_stream_pkg;

  localparam int FS_ADDR_W = 23;
  localparam int FS_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    HOLD = 3'd2,
    REQ  = 3'd3,
    WAIT = 3'd4
  } fs_state_t;

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO.
// push/din write, pop/dout read head, flush empties, count/empty/full status.
module stream_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so sample is clean after reset.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_stream_reader.sv
// flash_stream_reader: streams a flash word range into a FWFT buffer.
// start/range/loop/stop control, fm_* manager handshake, sample_* consumer side.
module flash_stream_reader
  import flash_stream_pkg::*;
#(
  parameter int ADDR_W     = FS_ADDR_W,
  parameter int DATA_W     = FS_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              loop,
  input  logic              stop,
  output logic              fm_writemode,
  output logic [ADDR_W-1:0] fm_raddr,
  output logic              fm_doread,
  input  logic              fm_busy,
  input  logic [DATA_W-1:0] fm_rdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              active,
  output logic              done,
  output logic              error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  fs_state_t         state;
  logic [ADDR_W-1:0] first_q;
  logic [ADDR_W-1:0] last_q;
  logic              loop_q;
  logic              stop_q;
  logic [TW-1:0]     tcnt;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              flush;
  logic              tmo;
  logic              room;
  logic              at_end;
  logic              bad_rng;

  assign fm_writemode = 1'b0;
  assign sample_valid = !empty;
  assign pop          = sample_valid && sample_ready;
  assign bad_rng      = end_addr < start_addr;
  assign flush        = (state == IDLE) && start && !bad_rng;
  // A stop seen during WAIT turns the returning word into a discard.
  assign push         = (state == WAIT) && !fm_busy
                        && !stop_q && !stop;
  assign tmo          = (tcnt == TW'(TIMEOUT - 1));
  assign at_end       = (fm_raddr == last_q);
  // Space after this cycle's push: a pop or at least two free slots now.
  assign room         = pop || (count < CW'(FIFO_DEPTH - 1));

  stream_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .push (push),
    .din  (fm_rdata),
    .pop  (pop),
    .dout (sample),
    .count(count),
    .empty(empty),
    .full (full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      fm_raddr  <= '0;
      first_q   <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      stop_q    <= 1'b0;
      tcnt      <= '0;
      fm_doread <= 1'b0;
      active    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      tcnt <= tcnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (start && bad_rng) begin
            error <= 1'b1;
            done  <= 1'b1;
          end else if (start) begin
            error    <= 1'b0;
            first_q  <= start_addr;
            last_q   <= end_addr;
            loop_q   <= loop;
            fm_raddr <= start_addr;
            active   <= 1'b1;
            tcnt     <= '0;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (stop) begin
            state  <= IDLE;
            active <= 1'b0;
            done   <= 1'b1;
          end else if (!fm_busy) begin
            state     <= REQ;
            fm_doread <= 1'b1;
            tcnt      <= '0;
          end else if (tmo) begin
            error  <= 1'b1;
            state  <= IDLE;
            active <= 1'b0;
            done   <= 1'b1;
          end
        end
        HOLD: begin
          if (stop) begin
            state  <= IDLE;
            active <= 1'b0;
            done   <= 1'b1;
          end else if (!full) begin
            state     <= REQ;
            fm_doread <= 1'b1;
            tcnt      <= '0;
          end
        end
        REQ: begin
          if (fm_busy) begin
            fm_doread <= 1'b0;
            stop_q    <= stop;
            tcnt      <= '0;
            state     <= WAIT;
          end else if (stop) begin
            fm_doread <= 1'b0;
            state     <= IDLE;
            active    <= 1'b0;
            done      <= 1'b1;
          end else if (tmo) begin
            fm_doread <= 1'b0;
            error     <= 1'b1;
            state     <= IDLE;
            active    <= 1'b0;
            done      <= 1'b1;
          end
        end
        WAIT: begin
          if (stop) begin
            stop_q <= 1'b1;
          end
          if (!fm_busy) begin
            tcnt <= '0;
            if (stop_q || stop || (at_end && !loop_q)) begin
              state  <= IDLE;
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              fm_raddr <= at_end ? first_q : fm_raddr + 1'b1;
              if (room) begin
                state     <= REQ;
                fm_doread <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end
          end else if (tmo) begin
            error  <= 1'b1;
            state  <= IDLE;
            active <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          fm_doread <= 1'b0;
          active    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
